// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data/instruction memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REQ_ST = 2'd0,
    REQ_LD = 2'd1,
    REQ_IF = 2'd2
  } req_id_e;

  localparam logic [3:0] RD_BE = 4'hF;
  localparam int         LAT_W = 3;

  // One-hot winner (bit index = requester ID) to encoded requester ID.
  function automatic req_id_e onehot_to_id(input logic [2:0] oh);
    req_id_e id;
    id = REQ_ST;
    if (oh[REQ_LD]) id = REQ_LD;
    if (oh[REQ_IF]) id = REQ_IF;
    return id;
  endfunction

endpackage

// File: rtl/dmem_port_arb_if.sv
// Requester and memory-macro signals of the memory port arbiter.
// slave is the arbiter side, master is the requester/memory side.
interface dmem_port_arb_if;
  logic        st_req_i;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic [3:0]  st_be_i;
  logic        st_gnt_o;
  logic        ld_req_i;
  logic [31:0] ld_addr_i;
  logic        ld_gnt_o;
  logic        ld_rvalid_o;
  logic [31:0] ld_rdata_o;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  modport slave (
    input  st_req_i, st_addr_i, st_data_i, st_be_i, ld_req_i, ld_addr_i,
           if_req_i, if_addr_i, mem_rdata_i,
    output st_gnt_o, ld_gnt_o, ld_rvalid_o, ld_rdata_o, if_gnt_o, if_rvalid_o,
           if_rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
           busy_o
  );

  modport master (
    output st_req_i, st_addr_i, st_data_i, st_be_i, ld_req_i, ld_addr_i,
           if_req_i, if_addr_i, mem_rdata_i,
    input  st_gnt_o, ld_gnt_o, ld_rvalid_o, ld_rdata_o, if_gnt_o, if_rvalid_o,
           if_rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
           busy_o
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational fixed-priority picker (store > load > fetch); the starve
// flag promotes a pending fetch above everything else.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic       i_st_req,
  input  logic       i_ld_req,
  input  logic       i_if_req,
  input  logic       i_starve,
  output logic [2:0] o_win,
  output logic       o_any
);

  always_comb begin
    o_win = 3'b000;
    if (i_starve && i_if_req) o_win[REQ_IF] = 1'b1;
    else if (i_st_req)        o_win[REQ_ST] = 1'b1;
    else if (i_ld_req)        o_win[REQ_LD] = 1'b1;
    else if (i_if_req)        o_win[REQ_IF] = 1'b1;
  end

  assign o_any = i_st_req | i_ld_req | i_if_req;

endmodule

// File: rtl/dmem_port_arb.sv
// Single-ported memory arbiter/sequencer for store, load and fetch requesters.
// Optional fetch starvation guard: define DMEM_ARB_STARVE_EN.
module dmem_port_arb
  import dmem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_MAX  = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  dmem_port_arb_if.slave   bus
);

  state_e          r_state;
  req_id_e         r_win;
  logic [LAT_W-1:0] r_lat;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_be;

  logic [2:0]      w_win;
  logic            w_any;
  logic            w_starve;
  logic            w_arb;
  logic            w_issue;
  logic            w_done;
  req_id_e         w_win_id;

`ifdef DMEM_ARB_STARVE_EN
  logic [3:0] r_starve;

  assign w_starve = (r_starve >= 4'(STARVE_MAX));

  // Counts IDLE arbitrations fetch loses while requesting; any gap clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve <= 4'd0;
    end else if (r_state == ST_IDLE) begin
      if (!bus.if_req_i || w_win[REQ_IF]) r_starve <= 4'd0;
      else if (r_starve != 4'hF)          r_starve <= r_starve + 4'd1;
    end
  end
`else
  assign w_starve = 1'b0;
`endif

  dmem_arb_pick u_pick (
    .i_st_req (bus.st_req_i),
    .i_ld_req (bus.ld_req_i),
    .i_if_req (bus.if_req_i),
    .i_starve (w_starve),
    .o_win    (w_win),
    .o_any    (w_any)
  );

  assign w_win_id = onehot_to_id(w_win);
  assign w_arb    = (r_state == ST_IDLE) && w_any;
  assign w_issue  = (r_state == ST_ISSUE);
  assign w_done   = (r_state == ST_WAIT) && (r_lat == LAT_W'(MEM_LATENCY));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_win   <= REQ_ST;
      r_lat   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_win   <= w_win_id;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_win == REQ_ST) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_WAIT;
            r_lat   <= LAT_W'(1);
          end
        end
        ST_WAIT: begin
          if (r_lat == LAT_W'(MEM_LATENCY)) begin
            r_state <= ST_IDLE;
            r_lat   <= '0;
          end else begin
            r_lat   <= r_lat + LAT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Payload is only observable while gated by ISSUE, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_arb) begin
      case (w_win_id)
        REQ_ST: begin
          r_addr  <= bus.st_addr_i;
          r_wdata <= bus.st_data_i;
          r_be    <= bus.st_be_i;
        end
        REQ_LD: begin
          r_addr  <= bus.ld_addr_i;
          r_wdata <= 32'd0;
          r_be    <= RD_BE;
        end
        default: begin
          r_addr  <= bus.if_addr_i;
          r_wdata <= 32'd0;
          r_be    <= RD_BE;
        end
      endcase
    end
  end

  assign bus.st_gnt_o    = w_issue && (r_win == REQ_ST);
  assign bus.ld_gnt_o    = w_issue && (r_win == REQ_LD);
  assign bus.if_gnt_o    = w_issue && (r_win == REQ_IF);
  assign bus.ld_rvalid_o = w_done  && (r_win == REQ_LD);
  assign bus.if_rvalid_o = w_done  && (r_win == REQ_IF);
  assign bus.ld_rdata_o  = bus.mem_rdata_i;
  assign bus.if_rdata_o  = bus.mem_rdata_i;

  assign bus.mem_en_o    = w_issue;
  assign bus.mem_we_o    = w_issue && (r_win == REQ_ST);
  assign bus.mem_addr_o  = w_issue ? r_addr  : 32'd0;
  assign bus.mem_wdata_o = w_issue ? r_wdata : 32'd0;
  assign bus.mem_be_o    = w_issue ? r_be    : 4'd0;
  assign bus.busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_port_arb.sv
// Directed bench for dmem_port_arb: a latency-2 instance with a memory model
// and read-data scoreboard, plus a latency-1 instance for back-to-back reads.
module tb_dmem_port_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_port_arb_if bus2 ();
  dmem_port_arb_if bus1 ();

  dmem_port_arb #(.MEM_LATENCY(2), .STARVE_MAX(3)) u_dut2 (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus2)
  );
  dmem_port_arb #(.MEM_LATENCY(1)) u_dut1 (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus1)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_q [$];
  logic        rd_pend;
  logic [31:0] rd_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    bus2.st_req_i = 1'b0; bus2.ld_req_i = 1'b0; bus2.if_req_i = 1'b0;
    bus1.st_req_i = 1'b0; bus1.ld_req_i = 1'b0; bus1.if_req_i = 1'b0;
  endtask

  // Memory model for bus2 plus the rvalid scoreboard; advances one cycle.
  task automatic tick();
    logic [31:0] w;
    logic [31:0] a;
    rd_pend = 1'b0;
    if (bus2.mem_en_o === 1'b1) begin
      a = bus2.mem_addr_o;
      w = mem.exists(a) ? mem[a] : 32'd0;
      if (bus2.mem_we_o === 1'b1) begin
        for (int b = 0; b < 4; b++)
          if (bus2.mem_be_o[b]) w[8*b +: 8] = bus2.mem_wdata_o[8*b +: 8];
        mem[a] = w;
      end else begin
        rd_pend = 1'b1;
        rd_val  = w;
      end
    end
    @(posedge clk);
    #1;
    if (rd_pend) bus2.mem_rdata_i = rd_val;
    if (bus2.ld_rvalid_o === 1'b1 || bus2.if_rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", {30'd0, bus2.ld_rvalid_o, bus2.if_rvalid_o}, 32'd0);
      end else begin
        w = exp_q.pop_front();
        if (bus2.ld_rvalid_o === 1'b1) check("ld_rdata", bus2.ld_rdata_o, w);
        else                           check("if_rdata", bus2.if_rdata_o, w);
      end
    end
  endtask

  initial begin
    int st_cnt, if_cnt, if_cyc;
    logic exp_g, exp_v;

    rst_n = 1'b0;
    rd_pend = 1'b0;
    rd_val = 32'd0;
    bus2.mem_rdata_i = 32'd0;
    bus1.mem_rdata_i = 32'd0;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h300] = 32'hCAFEF00D;

    // Reset with every request high: outputs must stay quiet.
    bus2.st_req_i = 1'b1; bus2.st_addr_i = 32'h40; bus2.st_data_i = 32'h11223344; bus2.st_be_i = 4'hC;
    bus2.ld_req_i = 1'b1; bus2.ld_addr_i = 32'h44; bus2.if_req_i = 1'b1; bus2.if_addr_i = 32'h48;
    bus1.st_req_i = 1'b1; bus1.st_addr_i = 32'h40; bus1.st_data_i = 32'h11223344; bus1.st_be_i = 4'hC;
    bus1.ld_req_i = 1'b1; bus1.ld_addr_i = 32'h10; bus1.if_req_i = 1'b1; bus1.if_addr_i = 32'h48;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl2", {20'd0, bus2.st_gnt_o, bus2.ld_gnt_o, bus2.ld_rvalid_o, bus2.if_gnt_o,
                        bus2.if_rvalid_o, bus2.mem_en_o, bus2.mem_we_o, bus2.busy_o, bus2.mem_be_o}, 32'd0);
    check("rst_addr2", bus2.mem_addr_o, 32'd0);
    check("rst_wdata2", bus2.mem_wdata_o, 32'd0);
    check("rst_ctrl1", {20'd0, bus1.st_gnt_o, bus1.ld_gnt_o, bus1.ld_rvalid_o, bus1.if_gnt_o,
                        bus1.if_rvalid_o, bus1.mem_en_o, bus1.mem_we_o, bus1.busy_o, bus1.mem_be_o}, 32'd0);
    check("rst_addr1", bus1.mem_addr_o, 32'd0);

    rst_n = 1'b1;
    tick();
    check("rel_st_gnt2", {31'd0, bus2.st_gnt_o}, 32'd1);
    check("rel_we2", {31'd0, bus2.mem_we_o}, 32'd1);
    check("rel_addr2", bus2.mem_addr_o, 32'h40);
    check("rel_st_gnt1", {31'd0, bus1.st_gnt_o}, 32'd1);
    check("rel_ld_gnt1", {31'd0, bus1.ld_gnt_o}, 32'd0);
    clear_reqs();
    tick();
    check("rel_idle2", {31'd0, bus2.busy_o}, 32'd0);

    // Single read, latency 2.
    bus2.ld_req_i = 1'b1; bus2.ld_addr_i = 32'h100;
    exp_q.push_back(32'hDEADBEEF);
    tick();
    check("rd_gnt", {31'd0, bus2.ld_gnt_o}, 32'd1);
    check("rd_addr", bus2.mem_addr_o, 32'h100);
    check("rd_be", {28'd0, bus2.mem_be_o}, 32'hF);
    check("rd_we", {31'd0, bus2.mem_we_o}, 32'd0);
    bus2.ld_req_i = 1'b0;
    tick();
    check("rd_rvalid_c2", {31'd0, bus2.ld_rvalid_o}, 32'd0);
    tick();
    check("rd_rvalid_c3", {31'd0, bus2.ld_rvalid_o}, 32'd1);
    tick();
    check("rd_idle_c4", {31'd0, bus2.busy_o}, 32'd0);

    // Store and load to the same address raised together.
    bus2.st_req_i = 1'b1; bus2.st_addr_i = 32'h200; bus2.st_data_i = 32'h55; bus2.st_be_i = 4'h1;
    bus2.ld_req_i = 1'b1; bus2.ld_addr_i = 32'h200;
    exp_q.push_back(32'h00000055);
    tick();
    check("col_st_gnt", {31'd0, bus2.st_gnt_o}, 32'd1);
    check("col_we", {31'd0, bus2.mem_we_o}, 32'd1);
    check("col_ld_gnt_c1", {31'd0, bus2.ld_gnt_o}, 32'd0);
    check("col_wdata", bus2.mem_wdata_o, 32'h55);
    check("col_be", {28'd0, bus2.mem_be_o}, 32'h1);
    bus2.st_req_i = 1'b0;
    tick();
    check("col_ld_gnt_c2", {31'd0, bus2.ld_gnt_o}, 32'd0);
    tick();
    check("col_ld_gnt_c3", {31'd0, bus2.ld_gnt_o}, 32'd1);
    check("col_ld_addr", bus2.mem_addr_o, 32'h200);
    bus2.ld_req_i = 1'b0;
    tick();
    tick();
    check("col_rvalid_c5", {31'd0, bus2.ld_rvalid_o}, 32'd1);
    tick();

    // Store and fetch held together.
    bus2.st_req_i = 1'b1; bus2.st_addr_i = 32'h400; bus2.st_data_i = 32'h0; bus2.st_be_i = 4'hF;
    bus2.if_req_i = 1'b1; bus2.if_addr_i = 32'h300;
`ifdef DMEM_ARB_STARVE_EN
    exp_q.push_back(32'hCAFEF00D);
`endif
    st_cnt = 0; if_cnt = 0; if_cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus2.st_gnt_o === 1'b1) st_cnt++;
      if (bus2.if_gnt_o === 1'b1) begin if_cnt++; if_cyc = c; end
      if (c == 8) begin bus2.st_req_i = 1'b0; bus2.if_req_i = 1'b0; end
    end
    repeat (3) tick();
`ifdef DMEM_ARB_STARVE_EN
    check("stv_st_cnt", st_cnt, 3);
    check("stv_if_cnt", if_cnt, 1);
    check("stv_if_cyc", if_cyc, 7);
`else
    check("stv_st_cnt", st_cnt, 4);
    check("stv_if_cnt", if_cnt, 0);
`endif

    // Reset during the WAIT of a fetch abandons it.
    bus2.if_req_i = 1'b1; bus2.if_addr_i = 32'h300;
    tick();
    check("mid_if_gnt", {31'd0, bus2.if_gnt_o}, 32'd1);
    bus2.if_req_i = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_busy", {31'd0, bus2.busy_o}, 32'd0);
    repeat (3) tick();
    check("mid_no_rvalid", {31'd0, bus2.if_rvalid_o}, 32'd0);
    rst_n = 1'b1;
    bus2.if_req_i = 1'b1;
    exp_q.push_back(32'hCAFEF00D);
    tick();
    check("post_if_gnt", {31'd0, bus2.if_gnt_o}, 32'd1);
    bus2.if_req_i = 1'b0;
    tick();
    tick();
    check("post_if_rvalid", {31'd0, bus2.if_rvalid_o}, 32'd1);
    tick();

    // Load held across several accesses on the latency-1 instance.
    bus1.ld_req_i = 1'b1; bus1.ld_addr_i = 32'h10;
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp_g = (c == 1 || c == 4 || c == 7);
      exp_v = (c == 2 || c == 5 || c == 8);
      check($sformatf("held_gnt_c%0d", c), {31'd0, bus1.ld_gnt_o}, {31'd0, exp_g});
      check($sformatf("held_rvalid_c%0d", c), {31'd0, bus1.ld_rvalid_o}, {31'd0, exp_v});
      if (c == 8) bus1.ld_req_i = 1'b0;
    end

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
